vga_num_writer: RTL

Parametrised multi-channel decimal number writer for the VGA tile RAM. On a start pulse it snapshots up to CHANNELS unsigned binary values, converts each to BCD with a sequential double-dabble converter, and emits one tile-RAM write per digit (most significant first) with optional leading-zero blanking and overflow saturation. It sits between game logic (score, timer, health counters) and the tile/character RAM write port, replacing free-running per-digit division with an explicit start/busy/done handshake.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_bin2bcd.sv | 52 +++++
 rtl/vga_num_writer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile-RAM display blocks: glyph encoding,
// FSM state codes and BCD sizing helper.
package vga_pkg;

  localparam logic [2:0]  GLYPH_PREFIX = 3'b100;
  localparam logic [15:0] BLANK_CODE   = 16'h0000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Decimal digits needed for an n-bit unsigned value: ceil(n * log10(2)).
  function automatic int bcd_digits(input int n);
    int d;
    d = (n * 30103 + 99999) / 100000;
    return (d < 1) ? 1 : d;
  endfunction

  // Digit glyphs live at tile code 0x100 + value.
  function automatic logic [15:0] glyph_encode(input logic [3:0] v);
    return {7'b0, GLYPH_PREFIX, 2'b00, v};
  endfunction

endpackage

// File: rtl/vga_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, NUM_W shifts total,
// the first of which happens on the load edge itself.
module vga_bin2bcd
  import vga_pkg::*;
#(
  parameter  int NUM_W = 16,
  localparam int BCD_D = bcd_digits(NUM_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [NUM_W-1:0]   value,
  output logic               ready,
  output logic [4*BCD_D-1:0] bcd
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0]   sh;
  logic [CNT_W-1:0]   cnt;
  logic [4*BCD_D-1:0] adj;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      bcd <= {{(4*BCD_D-1){1'b0}}, value[NUM_W-1]};
      sh  <= value << 1;
      cnt <= CNT_W'(NUM_W - 1);
    end else if (cnt != '0) begin
      bcd <= {adj[4*BCD_D-2:0], sh[NUM_W-1]};
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign ready = (cnt == '0);

endmodule

// File: rtl/vga_num_writer.sv
// Multi-channel decimal number writer: snapshots values on start, converts each
// to BCD and writes one tile-RAM glyph per digit, most significant first.
module vga_num_writer
  import vga_pkg::*;
#(
  parameter int NUM_W     = 16,
  parameter int DIGITS    = 4,
  parameter int CHANNELS  = 2,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 137,
  parameter int CH_STRIDE = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHANNELS*NUM_W-1:0] nums,
  input  logic [CHANNELS-1:0]       blank_lz,
  output logic                      busy,
  output logic                      done,
  output logic                      we,
  output logic [ADDR_W-1:0]         addr,
  output logic [15:0]               dina
);

  localparam int BCD_D  = bcd_digits(NUM_W);
  localparam int PAD_D  = (BCD_D > DIGITS) ? BCD_D : DIGITS;
  localparam int CH_IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIG_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CH_IW-1:0]  CH_LAST  = CH_IW'(CHANNELS - 1);
  localparam logic [DIG_IW-1:0] DIG_LAST = DIG_IW'(DIGITS - 1);

  logic [1:0]                state;
  logic [CHANNELS*NUM_W-1:0] nums_q;
  logic [CHANNELS-1:0]       blank_q;
  logic [CH_IW-1:0]          ch;
  logic [DIG_IW-1:0]         dig;

  logic                      conv_load;
  logic [NUM_W-1:0]          conv_value;
  logic                      conv_ready;
  logic [4*BCD_D-1:0]        bcd;
  logic [4*PAD_D-1:0]        bcd_pad;

  logic                      last_dig;
  logic                      last_ch;
  logic                      sat;
  logic                      blank_en;
  logic                      zero_run;
  logic [3:0]                disp [DIGITS];
  logic [15:0]               code [DIGITS];
  logic [DIG_IW-1:0]         wr_dig;
  logic [ADDR_W-1:0]         addr_next;

  assign last_dig = (dig == DIG_LAST);
  assign last_ch  = (ch == CH_LAST);

  // The first channel converts straight from the inputs in the start cycle;
  // later channels come from the snapshot.
  always_comb begin
    conv_load  = 1'b0;
    conv_value = '0;
    if (state == ST_IDLE && start) begin
      conv_load  = 1'b1;
      conv_value = nums[NUM_W-1:0];
    end else if (state == ST_WRITE && last_dig && !last_ch) begin
      conv_load = 1'b1;
      for (int c = 1; c < CHANNELS; c++) begin
        if (CH_IW'(c) == ch + 1'b1) conv_value = nums_q[c*NUM_W +: NUM_W];
      end
    end
  end

  vga_bin2bcd #(.NUM_W(NUM_W)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (conv_load),
    .value (conv_value),
    .ready (conv_ready),
    .bcd   (bcd)
  );

  assign bcd_pad = (4*PAD_D)'(bcd);

  // Digit glyphs for the current channel, index 0 = most significant.
  always_comb begin
    sat      = 1'b0;
    blank_en = 1'b0;
    zero_run = 1'b1;
    for (int p = DIGITS; p < PAD_D; p++) begin
      if (bcd_pad[4*p +: 4] != 4'd0) sat = 1'b1;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (CH_IW'(c) == ch) blank_en = blank_q[c];
    end
    for (int i = 0; i < DIGITS; i++) begin
      disp[i]  = sat ? 4'd9 : bcd_pad[4*(DIGITS-1-i) +: 4];
      zero_run = zero_run && (disp[i] == 4'd0);
      if (blank_en && zero_run && (i != DIGITS - 1)) code[i] = BLANK_CODE;
      else                                           code[i] = glyph_encode(disp[i]);
    end
  end

  assign wr_dig    = (state == ST_CONVERT) ? '0 : dig + 1'b1;
  assign addr_next = ADDR_W'(BASE_ADDR) + ADDR_W'(ch) * ADDR_W'(CH_STRIDE)
                   + ADDR_W'(wr_dig);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      nums_q  <= '0;
      blank_q <= '0;
      ch      <= '0;
      dig     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      dina    <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            nums_q  <= nums;
            blank_q <= blank_lz;
            ch      <= '0;
            busy    <= 1'b1;
            state   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (conv_ready) begin
            we    <= 1'b1;
            addr  <= addr_next;
            dina  <= code[wr_dig];
            dig   <= '0;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!last_dig) begin
            we   <= 1'b1;
            addr <= addr_next;
            dina <= code[wr_dig];
            dig  <= wr_dig;
          end else if (!last_ch) begin
            ch    <= ch + 1'b1;
            state <= ST_CONVERT;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
